// File: rtl/my_sdram_pkg.sv
// Shared encodings for the SDRAM start-up sequencer and the helpers that reuse them.
// Commands are {cs_n, ras_n, cas_n, we_n}; states are plain constants so older tools can consume them.
package my_sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_DESL = 4'b1111;

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] WAIT_PWR = 4'd1;
  localparam logic [3:0] PRE      = 4'd2;
  localparam logic [3:0] WAIT_RP  = 4'd3;
  localparam logic [3:0] REF      = 4'd4;
  localparam logic [3:0] WAIT_RFC = 4'd5;
  localparam logic [3:0] MRS      = 4'd6;
  localparam logic [3:0] WAIT_MRD = 4'd7;
  localparam logic [3:0] DONE     = 4'd8;

  localparam int A10_BIT = 10;

  function automatic logic is_issue(input logic [3:0] st);
    return (st == PRE) || (st == REF) || (st == MRS);
  endfunction

endpackage

// File: rtl/my_sdram_timer.sv
// Loadable down-counter with zero flag; load beats count, and it holds at zero.
// Latency: zero flag reflects the registered count; counts only while i_en is high.
module my_sdram_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/my_sdram_init.sv
// SDRAM power-up sequencer: power-up wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE, then sticky done.
// Outputs registered; a command holds stable until i_cmd_ready, and stalls only stretch the sequence.
module my_sdram_init
  import my_sdram_pkg::*;
#(
  parameter int                T_POWERUP = 8000,
  parameter int                T_RP      = 2,
  parameter int                T_RFC     = 4,
  parameter int                T_MRD     = 2,
  parameter int                N_REFRESH = 8,
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] MODE_REG  = 12'h020
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_sdr_ena,
  output logic              o_cke,
  output logic              o_cmd_valid,
  input  logic              i_cmd_ready,
  output logic [3:0]        o_cmd,
  output logic [ADDR_W-1:0] o_addr,
  output logic [1:0]        o_ba,
  output logic              o_busy,
  output logic              o_memory_initialized
);

  localparam int TW = $clog2(T_POWERUP);
  localparam int RW = $clog2(N_REFRESH + 1);

  logic [3:0]        state_q, state_d;
  logic [RW-1:0]     ref_cnt_q, ref_cnt_d;
  logic              tmr_load, tmr_en, tmr_zero;
  logic [TW-1:0]     tmr_val;
  logic              accept;
  logic              cke_q, cke_d, vld_q, vld_d, busy_q, busy_d, init_q, init_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        ba_q, ba_d;

  assign accept = vld_q && i_cmd_ready;

  // Wait states load N-2 on accept so the next command lands exactly N cycles after the accept.
  always_comb begin
    state_d   = state_q;
    ref_cnt_d = ref_cnt_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_sdr_ena) begin
          state_d  = WAIT_PWR;
          tmr_load = 1'b1;
          tmr_val  = TW'(T_POWERUP - 1);
        end
      end
      WAIT_PWR: begin
        tmr_en = 1'b1;
        if (tmr_zero) state_d = PRE;
      end
      PRE: begin
        if (accept) begin
          state_d  = WAIT_RP;
          tmr_load = 1'b1;
          tmr_val  = TW'(T_RP - 2);
        end
      end
      WAIT_RP: begin
        tmr_en = 1'b1;
        if (tmr_zero) state_d = REF;
      end
      REF: begin
        if (accept) begin
          state_d   = WAIT_RFC;
          ref_cnt_d = ref_cnt_q + 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = TW'(T_RFC - 2);
        end
      end
      WAIT_RFC: begin
        tmr_en = 1'b1;
        if (tmr_zero) state_d = (ref_cnt_q == RW'(N_REFRESH)) ? MRS : REF;
      end
      MRS: begin
        if (accept) begin
          state_d  = WAIT_MRD;
          tmr_load = 1'b1;
          tmr_val  = TW'(T_MRD - 2);
        end
      end
      WAIT_MRD: begin
        tmr_en = 1'b1;
        if (tmr_zero) state_d = DONE;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs follow the next state so they are registered yet aligned with it.
  always_comb begin
    cke_d  = (state_d != IDLE);
    busy_d = (state_d != IDLE) && (state_d != DONE);
    init_d = (state_d == DONE);
    vld_d  = is_issue(state_d);
    cmd_d  = CMD_NOP;
    addr_d = '0;
    ba_d   = '0;
    case (state_d)
      IDLE: cmd_d = CMD_DESL;
      PRE: begin
        cmd_d           = CMD_PRE;
        addr_d[A10_BIT] = 1'b1;
      end
      REF: cmd_d = CMD_REF;
      MRS: begin
        cmd_d  = CMD_MRS;
        addr_d = MODE_REG;
      end
      default: cmd_d = CMD_NOP;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q   <= IDLE;
      ref_cnt_q <= '0;
      cke_q     <= 1'b0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      init_q    <= 1'b0;
      cmd_q     <= CMD_DESL;
      addr_q    <= '0;
      ba_q      <= '0;
    end else begin
      state_q   <= state_d;
      ref_cnt_q <= ref_cnt_d;
      cke_q     <= cke_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      init_q    <= init_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      ba_q      <= ba_d;
    end
  end

  my_sdram_timer #(.W(TW)) u_timer (
    .i_clk      (i_sys_clk),
    .i_rst      (i_sys_rst),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .i_en       (tmr_en),
    .o_zero     (tmr_zero)
  );

  assign o_cke                = cke_q;
  assign o_cmd_valid          = vld_q;
  assign o_cmd                = cmd_q;
  assign o_addr               = addr_q;
  assign o_ba                 = ba_q;
  assign o_busy               = busy_q;
  assign o_memory_initialized = init_q;

endmodule
